// File: rtl/union_ser_pkg.sv
// Shared types for the union word serializer: the packed-union word view,
// its control-view struct, the FSM state encoding and the default control tag.
package union_ser_pkg;

    localparam logic [1:0] KIND_CTL_DEFAULT = 2'b10;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  cnt_m1;
        logic [27:0] payload;
    } ctl_t;

    typedef union packed {
        logic [31:0] raw;
        ctl_t        ctl;
    } un_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/union_word_decode.sv
// Combinational view decode: picks the raw or control interpretation of a word
// and returns the byte count plus the payload to be shifted out.
module union_word_decode
    import union_ser_pkg::*;
#(
    parameter bit         CTL_VIEW_ENABLE = 1'b1,
    parameter logic [1:0] KIND_CTL        = KIND_CTL_DEFAULT
) (
    input  un_t         word,
    output logic [2:0]  nbytes,
    output logic [31:0] payload
);

    always_comb begin
        nbytes  = 3'd4;
        payload = word.raw;
        if (CTL_VIEW_ENABLE && (word.ctl.kind == KIND_CTL)) begin
            nbytes  = {1'b0, word.ctl.cnt_m1} + 3'd1;
            payload = {4'h0, word.ctl.payload};
        end
    end

endmodule

// File: rtl/union_word_serializer.sv
// Serializes union-typed 32-bit words into an LSB-first valid/ready byte stream.
// Optional trailing XOR parity byte when SER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a word
// SEND   | shifting out data bytes, one per accepted handshake
// PARITY | emitting the XOR of this word's data bytes (SER_PARITY_EN only)
module union_word_serializer
    import union_ser_pkg::*;
#(
    parameter bit         CTL_VIEW_ENABLE = 1'b1,
    parameter logic [1:0] KIND_CTL        = KIND_CTL_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  un_t        in_word,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
);

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [2:0]  nbytes_q, nbytes_d;
`ifdef SER_PARITY_EN
    logic [7:0]  par_q, par_d;
`endif

    logic [2:0]  dec_nbytes;
    logic [31:0] dec_payload;
    logic        last_data;

    union_word_decode #(
        .CTL_VIEW_ENABLE (CTL_VIEW_ENABLE),
        .KIND_CTL        (KIND_CTL)
    ) u_decode (
        .word    (in_word),
        .nbytes  (dec_nbytes),
        .payload (dec_payload)
    );

    // Counter never wraps: it is cleared on the final data byte instead.
    assign last_data = ({1'b0, cnt_q} == (nbytes_q - 3'd1));

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        nbytes_d  = nbytes_q;
`ifdef SER_PARITY_EN
        par_d     = par_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_byte  = 8'h00;
        out_last  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shreg_d  = dec_payload;
                    nbytes_d = dec_nbytes;
                    cnt_d    = 2'd0;
`ifdef SER_PARITY_EN
                    par_d    = 8'h00;
`endif
                    state_d  = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_byte  = shreg_q[7:0];
`ifdef SER_PARITY_EN
                out_last  = 1'b0;
`else
                out_last  = last_data;
`endif
                if (out_ready) begin
                    shreg_d = {8'h00, shreg_q[31:8]};
`ifdef SER_PARITY_EN
                    par_d   = par_q ^ shreg_q[7:0];
`endif
                    if (last_data) begin
                        cnt_d = 2'd0;
`ifdef SER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                out_valid = 1'b1;
                out_byte  = par_q;
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= 32'h0;
            cnt_q    <= 2'd0;
            nbytes_q <= 3'd0;
`ifdef SER_PARITY_EN
            par_q    <= 8'h00;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            nbytes_q <= nbytes_d;
`ifdef SER_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_union_word_serializer.sv
// Directed self-checking bench for union_word_serializer; a second instance
// with the control view disabled covers the raw-only decode.
module tb_union_word_serializer;

`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_word = 32'h0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    bit          sel = 1'b0;

    logic       a_in_ready, a_out_valid, a_out_last, a_busy;
    logic [7:0] a_out_byte;
    logic       b_in_ready, b_out_valid, b_out_last, b_busy;
    logic [7:0] b_out_byte;

    logic       o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [7:0] o_out_byte;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    union_word_serializer #(.CTL_VIEW_ENABLE(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_word   (in_word),
        .in_valid  (in_valid & ~sel),
        .in_ready  (a_in_ready),
        .out_byte  (a_out_byte),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_last  (a_out_last),
        .busy      (a_busy)
    );

    union_word_serializer #(.CTL_VIEW_ENABLE(1'b0)) dut_raw (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_word   (in_word),
        .in_valid  (in_valid & sel),
        .in_ready  (b_in_ready),
        .out_byte  (b_out_byte),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_last  (b_out_last),
        .busy      (b_busy)
    );

    assign o_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign o_out_valid = sel ? b_out_valid : a_out_valid;
    assign o_out_last  = sel ? b_out_last  : a_out_last;
    assign o_busy      = sel ? b_busy      : a_busy;
    assign o_out_byte  = sel ? b_out_byte  : a_out_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w);
        @(negedge clk);
        chk("send_in_ready", {31'b0, o_in_ready}, 32'd1);
        in_word  = w;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Expects n data bytes of dw (LSB first), plus a parity byte when enabled.
    task automatic collect(input string tag, input logic [31:0] dw, input int n, input bit bp);
        int         k = 0;
        int         cyc = 0;
        int         total;
        logic [7:0] par = 8'h00;
        logic [7:0] eb;
        logic       rdy;
        total = n + PAR;
        while (k < total && cyc < 60) begin
            @(negedge clk);
            rdy = bp ? (cyc % 3 == 0) : 1'b1;
            out_ready = rdy;
            eb = (k < n) ? dw[8*k +: 8] : par;
            chk({tag, ":valid"}, {31'b0, o_out_valid}, 32'd1);
            chk({tag, ":byte"}, {24'b0, o_out_byte}, {24'b0, eb});
            chk({tag, ":last"}, {31'b0, o_out_last}, {31'b0, (k == total - 1)});
            chk({tag, ":in_ready_lo"}, {31'b0, o_in_ready}, 32'd0);
            if (rdy) begin
                if (k < n) par = par ^ eb;
                k++;
            end
            cyc++;
        end
        chk({tag, ":bytes_done"}, k, total);
        if (!bp) chk({tag, ":cycles"}, cyc, total);
        @(negedge clk);
        chk({tag, ":in_ready_hi"}, {31'b0, o_in_ready}, 32'd1);
        chk({tag, ":busy_lo"}, {31'b0, o_busy}, 32'd0);
        chk({tag, ":valid_lo"}, {31'b0, o_out_valid}, 32'd0);
    endtask

    initial begin
        #12;
        chk("rst_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("rst_valid", {31'b0, o_out_valid}, 32'd0);
        chk("rst_last", {31'b0, o_out_last}, 32'd0);
        chk("rst_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_byte", {24'b0, o_out_byte}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        send(32'h00000001);
        collect("raw1", 32'h00000001, 4, 1'b0);

        send(32'hA0000055);
        collect("ctl3", 32'h00000055, 3, 1'b0);

        send(32'hBF123456);
        collect("ctl4", 32'h0F123456, 4, 1'b0);

        sel = 1'b1;
        send(32'hA0000055);
        collect("ctl_off", 32'hA0000055, 4, 1'b0);
        sel = 1'b0;

        send(32'h44332211);
        collect("bp", 32'h44332211, 4, 1'b1);

        send(32'h04030201);
        collect("par", 32'h04030201, 4, 1'b0);

        // Second word presented while the first is still being emitted.
        out_ready = 1'b1;
        @(negedge clk);
        in_word  = 32'h90000077;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_word = 32'h4433BBAA;
        collect("busy_w1", 32'h00000077, 2, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        collect("busy_w2", 32'h4433BBAA, 4, 1'b0);

        send(32'hDEADBEEF);
        @(negedge clk);
        out_ready = 1'b1;
        chk("rst_mid_b0", {24'b0, o_out_byte}, 32'hEF);
        @(negedge clk);
        chk("rst_mid_b1", {24'b0, o_out_byte}, 32'hBE);
        @(negedge clk);
        chk("rst_mid_b2", {24'b0, o_out_byte}, 32'hAD);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, o_out_valid}, 32'd0);
        chk("rst_mid_busy", {31'b0, o_busy}, 32'd0);
        chk("rst_mid_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("rst_mid_byte", {24'b0, o_out_byte}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h00000001);
        collect("post_rst", 32'h00000001, 4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
